// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD character path.
package lcd_pkg;

   localparam int unsigned LCD_CHARS  = 32;
   localparam int unsigned LCD_COLS   = 16;
   localparam int unsigned NIB_ADDR_W = 12;
   localparam int unsigned POS_W      = $clog2(LCD_CHARS);

   // Fetch FSM: two BRAM reads, one cycle to land the high nibble, then offer.
   typedef enum logic [2:0] {
      StIdle,
      StRdLo,
      StRdHi,
      StLatch,
      StOffer
   } fetch_state_e;

endpackage

// File: rtl/lcd_char_fetch.sv
// Walks the character BRAM one frame at a time, pairs nibbles into ASCII bytes
// and offers each byte with its screen position over a valid/ready handshake.
module lcd_char_fetch
   import lcd_pkg::*;
#(
   parameter logic [NIB_ADDR_W-1:0] BASE_ADDR = 12'h000,
   parameter int unsigned           NUM_CHARS = LCD_CHARS
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [NIB_ADDR_W-1:0] bram_addr_o,
   output logic                  bram_en_o,
   output logic                  bram_we_o,
   input  logic [3:0]            bram_do_i,
   output logic [7:0]            char_data_o,
   output logic [POS_W-1:0]      char_pos_o,
   output logic                  char_valid_o,
   input  logic                  char_ready_i
);

   localparam logic [POS_W-1:0] LastK = POS_W'(NUM_CHARS - 1);

   fetch_state_e          state_q, state_d;
   logic [POS_W-1:0]      k_q, k_d;
   logic [3:0]            lo_nib_q, lo_nib_d;
   logic [7:0]            char_data_q, char_data_d;
   logic [NIB_ADDR_W-1:0] addr_q, addr_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  en_q, en_d;
   logic                  valid_q, valid_d;

   // State and character index registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
      end
   end

   // Next-state logic; the index only advances on a handshake that is not the last.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               k_d     = '0;
               state_d = StRdLo;
            end
         end
         StRdLo:  state_d = StRdHi;
         StRdHi:  state_d = StLatch;
         StLatch: state_d = StOffer;
         StOffer: begin
            if (char_ready_i) begin
               if (k_q == LastK) begin
                  state_d = StIdle;
               end else begin
                  k_d     = k_q + 1'b1;
                  state_d = StRdLo;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output next-values decoded from the upcoming state so every output is a flop.
   always_comb begin
      busy_d      = (state_d != StIdle);
      en_d        = (state_d == StRdLo) || (state_d == StRdHi);
      valid_d     = (state_d == StOffer);
      done_d      = (state_q == StOffer) && char_ready_i && (k_q == LastK);
      // Address arithmetic is modulo 4096, so a base near the top wraps to 0.
      addr_d      = en_d ? BASE_ADDR + NIB_ADDR_W'({k_d, 1'b0})
                                     + NIB_ADDR_W'(state_d == StRdHi)
                         : addr_q;
      // Read data lags the address by one cycle: low nibble arrives during RD_HI,
      // high nibble during LATCH.
      lo_nib_d    = (state_q == StRdHi) ? bram_do_i : lo_nib_q;
      char_data_d = (state_q == StLatch) ? {bram_do_i, lo_nib_q} : char_data_q;
   end

   // Output and datapath registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         en_q        <= 1'b0;
         valid_q     <= 1'b0;
         addr_q      <= '0;
         lo_nib_q    <= '0;
         char_data_q <= '0;
      end else begin
         busy_q      <= busy_d;
         done_q      <= done_d;
         en_q        <= en_d;
         valid_q     <= valid_d;
         addr_q      <= addr_d;
         lo_nib_q    <= lo_nib_d;
         char_data_q <= char_data_d;
      end
   end

   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign bram_addr_o  = addr_q;
   assign bram_en_o    = en_q;
   assign bram_we_o    = 1'b0;
   assign char_data_o  = char_data_q;
   assign char_pos_o   = k_q;
   assign char_valid_o = valid_q;

endmodule

// File: tb/tb_lcd_char_fetch.sv
// Directed bench for lcd_char_fetch: default frame, backpressure, start corner
// cases, mid-frame reset and base-address wrap on a second instance.
module tb_lcd_char_fetch;

   logic        clk;
   logic        rst;
   logic [3:0]  mem [4096];

   logic        start_a, busy_a, done_a, en_a, we_a, valid_a, ready_a;
   logic [11:0] addr_a;
   logic [3:0]  do_a;
   logic [7:0]  data_a;
   logic [4:0]  pos_a;

   logic        start_b, busy_b, done_b, en_b, we_b, valid_b, ready_b;
   logic [11:0] addr_b;
   logic [3:0]  do_b;
   logic [7:0]  data_b;
   logic [4:0]  pos_b;

   int n_checks = 0;
   int n_fail   = 0;
   int hs_a     = 0;
   int hs_base;

   lcd_char_fetch #(.BASE_ADDR(12'h000), .NUM_CHARS(32)) dut_a (
      .clk_i(clk), .rst_i(rst), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
      .bram_addr_o(addr_a), .bram_en_o(en_a), .bram_we_o(we_a), .bram_do_i(do_a),
      .char_data_o(data_a), .char_pos_o(pos_a), .char_valid_o(valid_a),
      .char_ready_i(ready_a)
   );

   lcd_char_fetch #(.BASE_ADDR(12'hFFE), .NUM_CHARS(2)) dut_b (
      .clk_i(clk), .rst_i(rst), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
      .bram_addr_o(addr_b), .bram_en_o(en_b), .bram_we_o(we_b), .bram_do_i(do_b),
      .char_data_o(data_b), .char_pos_o(pos_b), .char_valid_o(valid_b),
      .char_ready_i(ready_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous-read BRAM, one read port per instance over shared contents.
   always @(posedge clk) begin
      if (en_a) do_a <= mem[addr_a];
      if (en_b) do_b <= mem[addr_b];
   end

   always @(posedge clk) if (valid_a && ready_a) hs_a <= hs_a + 1;

   function automatic logic [7:0] exp_char(input int k);
      if (k < 16)      return 8'(8'h41 + k);
      else if (k < 31) return 8'(8'h61 + k - 16);
      else             return 8'h7C;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_zero_a(input string tag);
      check({tag, " busy"},  32'(busy_a),  0);
      check({tag, " done"},  32'(done_a),  0);
      check({tag, " addr"},  32'(addr_a),  0);
      check({tag, " en"},    32'(en_a),    0);
      check({tag, " we"},    32'(we_a),    0);
      check({tag, " data"},  32'(data_a),  0);
      check({tag, " pos"},   32'(pos_a),   0);
      check({tag, " valid"}, 32'(valid_a), 0);
   endtask

   task automatic check_offer_a(input string tag, input int k);
      check({tag, " valid"}, 32'(valid_a), 1);
      check({tag, " pos"},   32'(pos_a),   32'(k));
      check({tag, " data"},  32'(data_a),  32'(exp_char(k)));
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 4'h0;
      for (int k = 0; k < 32; k++) begin
         logic [7:0] c;
         c = exp_char(k);
         mem[2*k]   = c[3:0];
         mem[2*k+1] = c[7:4];
      end
      mem[12'hFFE] = 4'h1;
      mem[12'hFFF] = 4'h5;

      // 1: reset for 3 cycles, release, idle outputs stay 0.
      rst = 1'b1; start_a = 0; ready_a = 0; start_b = 0; ready_b = 0;
      tick(3);
      check_zero_a("rst_held");
      rst = 1'b0;
      tick(3);
      check_zero_a("idle");

      // 2: full frame, ready held high.
      ready_a = 1; start_a = 1;
      tick();
      start_a = 0;
      check("f1 busy E", 32'(busy_a), 1);
      check("f1 en E",   32'(en_a),   1);
      check("f1 addr E", 32'(addr_a), 12'h000);
      tick();
      check("f1 addr E1", 32'(addr_a), 12'h001);
      tick();
      check("f1 en E2",    32'(en_a),    0);
      check("f1 valid E2", 32'(valid_a), 0);
      tick();
      hs_base = hs_a;
      for (int k = 0; k < 32; k++) begin
         check_offer_a("f1 offer", k);
         tick();
         if (k < 31) begin
            check("f1 gap valid", 32'(valid_a), 0);
            check("f1 gap en",    32'(en_a),    1);
            check("f1 gap done",  32'(done_a),  0);
            tick(3);
         end
      end
      check("f1 done",  32'(done_a),  1);
      check("f1 busy",  32'(busy_a),  0);
      check("f1 valid", 32'(valid_a), 0);
      check("f1 count", 32'(hs_a - hs_base), 32);
      tick();
      check("f1 done pulse", 32'(done_a), 0);
      check("f1 busy after", 32'(busy_a), 0);

      // 3 + 4a: restart at char 3 ignored, backpressure at char 5.
      start_a = 1;
      tick();
      start_a = 0;
      tick(3);
      hs_base = hs_a;
      for (int k = 0; k < 32; k++) begin
         check_offer_a("f2 offer", k);
         if (k == 3) start_a = 1;
         if (k == 5) begin
            ready_a = 0;
            for (int w = 0; w < 5; w++) begin
               tick();
               check("bp valid", 32'(valid_a), 1);
               check("bp data",  32'(data_a),  8'h46);
               check("bp pos",   32'(pos_a),   5);
               check("bp en",    32'(en_a),    0);
            end
            ready_a = 1;
         end
         tick();
         start_a = 0;
         if (k < 31) tick(3);
      end
      check("f2 done",  32'(done_a), 1);
      check("f2 count", 32'(hs_a - hs_base), 32);

      // 4b: start in the done cycle begins a new frame.
      start_a = 1;
      tick();
      start_a = 0;
      check("f3 done pulse", 32'(done_a), 0);
      check("f3 busy",       32'(busy_a), 1);
      tick(3);
      check_offer_a("f3 first", 0);

      // 5: asynchronous reset mid-frame at char 10.
      for (int k = 0; k < 10; k++) tick(4);
      check_offer_a("f3 pre-rst", 10);
      rst = 1'b1;
      #1;
      check_zero_a("async_rst");
      tick(2);
      rst = 1'b0;
      tick();
      check_zero_a("post_rst");
      start_a = 1;
      tick();
      start_a = 0;
      tick(3);
      check_offer_a("f4 first", 0);
      ready_a = 0;

      // 6: base 12'hFFE, address wraps to 000 for char 1.
      ready_b = 1; start_b = 1;
      tick();
      start_b = 0;
      check("wrap addr0", 32'(addr_b), 12'hFFE);
      check("wrap en0",   32'(en_b),   1);
      tick();
      check("wrap addr1", 32'(addr_b), 12'hFFF);
      tick(2);
      check("wrap c0 valid", 32'(valid_b), 1);
      check("wrap c0 pos",   32'(pos_b),   0);
      check("wrap c0 data",  32'(data_b),  8'h51);
      tick();
      check("wrap addr2", 32'(addr_b), 12'h000);
      tick();
      check("wrap addr3", 32'(addr_b), 12'h001);
      tick(2);
      check("wrap c1 valid", 32'(valid_b), 1);
      check("wrap c1 pos",   32'(pos_b),   1);
      check("wrap c1 data",  32'(data_b),  8'h41);
      tick();
      check("wrap done", 32'(done_b), 1);
      check("wrap busy", 32'(busy_b), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/lcd_char_fetch.md
# lcd_char_fetch

Read-side companion of the character BRAM (4096 x 4-bit, single port, synchronous read). It walks the 32-character display buffer, two nibbles per character, and assembles each ASCII byte. Each byte is offered with its screen position to the downstream LCD command/write engine over a valid/ready handshake. It sits between the character BRAM and the LCD write sequencer and drives only the BRAM read port.

## Interface
- BASE_ADDR, 12'h000, nibble address of character 0 (must be even)
- NUM_CHARS, 32, characters per frame (1..32)

- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to fetch one frame; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until the frame completes
- done  out  1  one-cycle pulse after the last character handshake
- bram_addr  out  12  nibble address to the BRAM ADDR
- bram_en  out  1  BRAM EN
- bram_we  out  1  BRAM WE; constant 0
- bram_do  in  4  BRAM DO; valid the cycle after address and enable are sampled
- char_data  out  8  assembled character, {high nibble, low nibble}
- char_pos  out  5  index k of char_data (0 = line 1 col 0, 16 = line 2 col 0)
- char_valid  out  1  char_data/char_pos valid
- char_ready  in  1  downstream accepts when char_valid && char_ready at a rising edge

## Operation
- Character k occupies nibble addresses A = BASE_ADDR + 2k (low nibble) and A+1 (high nibble). Addition is modulo 4096, so addresses wrap past 12'hFFF.
- FSM states: IDLE, RD_LO, RD_HI, LATCH, OFFER.
- IDLE: bram_en=0, busy=0. If start=1: k<=0 and go to RD_LO.
- RD_LO: bram_addr = BASE+2k, bram_en=1. Go to RD_HI.
- RD_HI: bram_addr = BASE+2k+1, bram_en=1. Capture bram_do into lo_nib. Go to LATCH.
- LATCH: bram_en=0. Capture bram_do into hi_nib. Go to OFFER.
- OFFER: char_valid=1. char_data and char_pos are held stable until handshake. On handshake:
  - if k = NUM_CHARS-1, go to IDLE and assert done for exactly that next cycle;
  - otherwise k<=k+1 and go to RD_LO.
- start is ignored outside IDLE. start in the same cycle done is high is accepted, because that cycle is IDLE.
- char_ready is ignored outside OFFER.
- There is no abort input. Only reset terminates a frame.

## Timing
- Reset (asynchronous, immediate) sets state=IDLE, k=0, and drives every output to 0: busy, done, bram_addr, bram_en, bram_we, char_data, char_pos, char_valid.
- Reset asserted mid-frame discards the partial frame. After reset is released, the next start begins at k=0.
- All outputs are registered or decoded from the registered state only. No combinational path runs from char_ready or start to any output.
- Latency: start sampled at edge E -> char_valid high after edge E+3.
- With char_ready held high, each character takes 4 cycles. A full 32-character frame takes 3 + 31*4 + 1 cycles from E until the handshake of the last character. done follows on the next cycle.
- Backpressure: OFFER holds indefinitely, and bram_en stays 0 while waiting.

## Structure
- Shared package lcd_pkg:
  - the state enum;
  - LCD_CHARS = 32;
  - LCD_COLS = 16;
  - NIB_ADDR_W = 12.
- Single module, no sub-module. The BRAM is instantiated at the top level and connected port to port.
- bram_addr is formed combinationally from BASE_ADDR, k and state, then registered.

## Test plan
Tests 1-4 use the default BRAM contents: characters 0..15 are 0x41..0x50 ('A'..'P'), 16..30 are 0x61..0x6F, and 31 is 0x7C.
1. Reset held for 3 cycles, then released with no start -> every output stays 0 and state stays IDLE.
2. start pulse with char_ready=1 -> 32 handshakes in order:
   - char_pos 0..31;
   - char_data 0x41..0x50, 0x61..0x6F, 0x7C;
   - first char_valid at E+3, then one handshake every 4 cycles;
   - single done pulse; busy low after the frame.
3. char_ready low for 5 cycles while char_pos=5 is offered -> char_valid stays high, char_data=0x46 stays stable, bram_en=0; the handshake occurs on the first cycle ready is high.
4. Two edge cases:
   - start asserted again at char 3 -> no effect; exactly 32 characters are delivered.
   - start asserted in the done cycle -> a new frame begins, with char_pos=0 and char_data=0x41 at done+3.
5. reset asserted at char_pos=10 -> all outputs 0 asynchronously. A following start delivers char_pos=0, char_data=0x41.
6. BASE_ADDR=12'hFFE with memory nibbles FFE=1, FFF=5 -> char 0 = 0x51. Char 1 reads addresses 000/001 and yields 0x41, confirming the address wrap.
